// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package arb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int SEL_WIDTH = 2;

  localparam logic [SEL_WIDTH-1:0] REQ_FETCH = 2'd0;
  localparam logic [SEL_WIDTH-1:0] REQ_LSU   = 2'd1;
  localparam logic [SEL_WIDTH-1:0] REQ_DBG   = 2'd2;
  localparam logic [SEL_WIDTH-1:0] REQ_DMA   = 2'd3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the requesters, data memory and the port arbiter.
interface mem_port_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0]   Req;
  logic                 Mem_Ack;
  logic [NUM_REQ-1:0]   Grant;
  logic [SEL_WIDTH-1:0] Selector;
  logic                 Mem_Valid;
  logic                 Busy;
  logic                 Timeout_Err;

  modport master (
    input  Req, Mem_Ack,
    output Grant, Selector, Mem_Valid, Busy, Timeout_Err
  );

  modport slave (
    output Req, Mem_Ack,
    input  Grant, Selector, Mem_Valid, Busy, Timeout_Err
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] winner,
  output logic                 any_req
);

  // Walk the search order backwards so the earliest hit is written last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (Req[ptr + SEL_WIDTH'(i)]) begin
        winner  = ptr + SEL_WIDTH'(i);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single data-memory port; grant held until Mem_Ack.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);
  import arb_pkg::*;

  arb_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 valid_q, valid_d;

  logic [SEL_WIDTH-1:0] winner;
  logic                 any_req;
  logic                 expire;
  logic                 release_grant;

  rr_priority_pick u_pick (
    .Req     (bus.Req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            tmo_err_q, tmo_err_d;

  // Counter sits at zero in IDLE so it is already clear on the first BUSY cycle.
  always_comb begin
    wd_cnt_d  = (state_q == ARB_BUSY) ? wd_cnt_q + WD_W'(1) : '0;
    expire    = (state_q == ARB_BUSY) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    tmo_err_d = expire && !bus.Mem_Ack;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.Timeout_Err = tmo_err_q;
`else
  assign expire          = 1'b0;
  assign bus.Timeout_Err = 1'b0;
`endif

  assign release_grant = (state_q == ARB_BUSY) && (bus.Mem_Ack || expire);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_req)       state_d = ARB_BUSY;
      ARB_BUSY: if (release_grant) state_d = ARB_IDLE;
      default:                     state_d = ARB_IDLE;
    endcase
  end

  // Selector retains the last winner after release, so it doubles as the
  // record of whom to advance the pointer past.
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (state_q == ARB_IDLE && any_req) begin
      grant_d = NUM_REQ'(1) << winner;
      sel_d   = winner;
      valid_d = 1'b1;
    end else if (release_grant) begin
      grant_d = '0;
      valid_d = 1'b0;
      ptr_d   = sel_q + SEL_WIDTH'(1);
    end
  end

  assign bus.Grant     = grant_q;
  assign bus.Selector  = sel_q;
  assign bus.Mem_Valid = valid_q;
  assign bus.Busy      = valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; define ARB_TIMEOUT_EN to exercise the watchdog.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .NUM_REQ        (4),
    .SEL_WIDTH      (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic do_reset;
    reset       = 1'b1;
    bus.Req     = 4'b0000;
    bus.Mem_Ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.Grant !== 4'b0000) begin
        errors++; $display("FAIL reset_grant cyc %0d: got %b expected 0000", c, bus.Grant);
      end
      checks++;
      if (bus.Selector !== 2'd0) begin
        errors++; $display("FAIL reset_sel cyc %0d: got %0d expected 0", c, bus.Selector);
      end
      checks++;
      if ({bus.Mem_Valid, bus.Busy, bus.Timeout_Err} !== 3'b000) begin
        errors++; $display("FAIL reset_flags cyc %0d: got %b expected 000", c,
                           {bus.Mem_Valid, bus.Busy, bus.Timeout_Err});
      end
    end
  endtask

  task automatic test_single;
    bus.Req = 4'b0100;
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0100 || bus.Selector !== 2'd2) begin
      errors++; $display("FAIL single_grant: got %b/%0d expected 0100/2", bus.Grant, bus.Selector);
    end
    checks++;
    if (bus.Mem_Valid !== 1'b1 || bus.Busy !== 1'b1) begin
      errors++; $display("FAIL single_valid: got %b%b expected 11", bus.Mem_Valid, bus.Busy);
    end
    bus.Req = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0100 || bus.Mem_Valid !== 1'b1) begin
      errors++; $display("FAIL single_early_drop: got %b/%b expected 0100/1", bus.Grant, bus.Mem_Valid);
    end
    bus.Req = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0100 || bus.Selector !== 2'd2) begin
      errors++; $display("FAIL single_frozen: got %b/%0d expected 0100/2", bus.Grant, bus.Selector);
    end
    bus.Mem_Ack = 1'b1;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    checks++;
    if (bus.Grant !== 4'b0000 || bus.Selector !== 2'd2 || bus.Mem_Valid !== 1'b0) begin
      errors++; $display("FAIL single_release: got %b/%0d/%b expected 0000/2/0",
                         bus.Grant, bus.Selector, bus.Mem_Valid);
    end
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0001 || bus.Selector !== 2'd0) begin
      errors++; $display("FAIL single_ptr_wrap: got %b/%0d expected 0001/0", bus.Grant, bus.Selector);
    end
    bus.Mem_Ack = 1'b1;
    bus.Req     = 4'b0000;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
  endtask

  task automatic test_idle_ack;
    bus.Mem_Ack = 1'b1;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    checks++;
    if (bus.Grant !== 4'b0000 || bus.Mem_Valid !== 1'b0 || bus.Selector !== 2'd0) begin
      errors++; $display("FAIL idle_ack: got %b/%b/%0d expected 0000/0/0",
                         bus.Grant, bus.Mem_Valid, bus.Selector);
    end
    bus.Req = 4'b0011;
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0010 || bus.Selector !== 2'd1) begin
      errors++; $display("FAIL idle_ack_ptr: got %b/%0d expected 0010/1", bus.Grant, bus.Selector);
    end
    bus.Mem_Ack = 1'b1;
    bus.Req     = 4'b0000;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
  endtask

  task automatic test_fairness;
    logic [3:0] exp_grant;
    do_reset();
    bus.Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_grant = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++;
      if (bus.Grant !== exp_grant || bus.Selector !== 2'(k % 4)) begin
        errors++; $display("FAIL fair_grant %0d: got %b/%0d expected %b/%0d",
                           k, bus.Grant, bus.Selector, exp_grant, k % 4);
      end
      @(negedge clk);
      bus.Mem_Ack = 1'b1;
      @(negedge clk);
      bus.Mem_Ack = 1'b0;
      if (k == 4) bus.Req = 4'b0000;
      checks++;
      if (bus.Grant !== 4'b0000 || bus.Mem_Valid !== 1'b0) begin
        errors++; $display("FAIL fair_gap %0d: got %b/%b expected 0000/0", k, bus.Grant, bus.Mem_Valid);
      end
    end
  endtask

  task automatic test_skip;
    do_reset();
    bus.Req = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0001) begin
      errors++; $display("FAIL skip_first: got %b expected 0001", bus.Grant);
    end
    bus.Mem_Ack = 1'b1;
    bus.Req     = 4'b0000;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    bus.Req     = 4'b1001;
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b1000 || bus.Selector !== 2'd3) begin
      errors++; $display("FAIL skip_grant: got %b/%0d expected 1000/3", bus.Grant, bus.Selector);
    end
    bus.Mem_Ack = 1'b1;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    checks++;
    if (bus.Grant !== 4'b0000 || bus.Selector !== 2'd3) begin
      errors++; $display("FAIL skip_release: got %b/%0d expected 0000/3", bus.Grant, bus.Selector);
    end
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0001 || bus.Selector !== 2'd0) begin
      errors++; $display("FAIL skip_wrap: got %b/%0d expected 0001/0", bus.Grant, bus.Selector);
    end
    bus.Mem_Ack = 1'b1;
    bus.Req     = 4'b0000;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.Req = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0010) begin
      errors++; $display("FAIL rst_mid_pre: got %b expected 0010", bus.Grant);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.Grant !== 4'b0000 || bus.Mem_Valid !== 1'b0 || bus.Selector !== 2'd0) begin
      errors++; $display("FAIL rst_mid_async: got %b/%b/%0d expected 0000/0/0",
                         bus.Grant, bus.Mem_Valid, bus.Selector);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0010 || bus.Selector !== 2'd1 || bus.Mem_Valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_regrant: got %b/%0d/%b expected 0010/1/1",
                         bus.Grant, bus.Selector, bus.Mem_Valid);
    end
    bus.Mem_Ack = 1'b1;
    bus.Req     = 4'b0000;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    bus.Req = 4'b0011;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.Grant !== 4'b0001 || bus.Timeout_Err !== 1'b0) begin
        errors++; $display("FAIL tmo_hold %0d: got %b/%b expected 0001/0", c, bus.Grant, bus.Timeout_Err);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0000 || bus.Mem_Valid !== 1'b0 || bus.Timeout_Err !== 1'b1) begin
      errors++; $display("FAIL tmo_abort: got %b/%b/%b expected 0000/0/1",
                         bus.Grant, bus.Mem_Valid, bus.Timeout_Err);
    end
    @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0010 || bus.Timeout_Err !== 1'b0) begin
      errors++; $display("FAIL tmo_next: got %b/%b expected 0010/0", bus.Grant, bus.Timeout_Err);
    end
    bus.Req = 4'b0000;
    repeat (3) @(negedge clk);
    bus.Mem_Ack = 1'b1;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    checks++;
    if (bus.Grant !== 4'b0000 || bus.Timeout_Err !== 1'b0) begin
      errors++; $display("FAIL tmo_ack_wins: got %b/%b expected 0000/0", bus.Grant, bus.Timeout_Err);
    end
  endtask
`else
  task automatic test_no_timeout;
    do_reset();
    bus.Req = 4'b0001;
    repeat (24) @(negedge clk);
    checks++;
    if (bus.Grant !== 4'b0001 || bus.Mem_Valid !== 1'b1 || bus.Timeout_Err !== 1'b0) begin
      errors++; $display("FAIL no_tmo_hold: got %b/%b/%b expected 0001/1/0",
                         bus.Grant, bus.Mem_Valid, bus.Timeout_Err);
    end
    bus.Mem_Ack = 1'b1;
    bus.Req     = 4'b0000;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    checks++;
    if (bus.Grant !== 4'b0000) begin
      errors++; $display("FAIL no_tmo_release: got %b expected 0000", bus.Grant);
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    bus.Req     = 4'b0000;
    bus.Mem_Ack = 1'b0;
    test_reset();
    test_single();
    test_idle_ack();
    test_fairness();
    test_skip();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single data-memory port among four requesters: fetch refill, load/store stage, debug port and DMA. It drives the 2-bit `Selector` of the 4-to-1 address/write-data multiplexer in front of data memory. It holds each grant until the memory acknowledges the transaction. Sits between the pipeline MEM stage and the memory interface.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; fixed at 4 to match the 4-input mux.
- `SEL_WIDTH`, 2, width of `Selector`, equal to $clog2(NUM_REQ).
- `TIMEOUT_CYCLES`, 16, watchdog limit in cycles; used only when `ARB_TIMEOUT_EN` is defined; minimum 2.

Ports (single clock `clk`; reset `reset` is asynchronous, active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous active-high reset.
- `Req`  in  4  per-requester request level; the requester holds it until it sees its `Grant` bit and `Mem_Ack`.
- `Mem_Ack`  in  1  one-cycle pulse from memory: the current transaction is complete.
- `Grant`  out  4  one-hot registered grant; all zeros when idle.
- `Selector`  out  2  registered mux select; the index of the granted requester.
- `Mem_Valid`  out  1  registered; high while a transaction is granted.
- `Busy`  out  1  equals `Mem_Valid`; provided for pipeline stall logic.
- `Timeout_Err`  out  1  one-cycle pulse when the watchdog aborts a grant.

## Operation
- Two-state FSM:
  - IDLE → BUSY when any `Req` bit is high.
  - BUSY → IDLE on `Mem_Ack`, or on watchdog expiry.
- Winner selection in IDLE:
  - Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
  - The first asserted `Req` wins.
  - `ptr` is a 2-bit register; reset value is 0.
- On entering BUSY, the following are registered together on the same edge:
  - `Grant` = one-hot(winner), `Selector` = winner, `Mem_Valid` = 1.
- In BUSY:
  - `Grant` and `Selector` are frozen and `Req` changes are ignored.
  - A requester dropping `Req` early does not release the grant.
- On release:
  - `ptr` is set to winner+1 (wraps 3→0).
  - `Grant` is cleared and `Mem_Valid` drops.
  - `Selector` keeps the last winner.
- `Mem_Ack` received in IDLE is ignored and has no state effect.
- Reset values: state IDLE, `Grant`=0, `Selector`=0, `Mem_Valid`=0, `Busy`=0, `Timeout_Err`=0, `ptr`=0, watchdog count=0.
- Reset asserted mid-transaction clears all of the above immediately, without waiting for a clock edge. The in-flight memory transaction is abandoned.

## Timing
- `Req` first high in cycle N while IDLE → `Grant`/`Mem_Valid` high from cycle N+1.
- `Mem_Ack` in cycle M → `Grant`/`Mem_Valid` low from cycle M+1.
- The FSM spends at least one IDLE cycle between grants. The next arbitration happens in cycle M+1, so the next grant appears at M+2.
- `Mem_Ack` in the same cycle as grant entry cannot occur, because `Mem_Valid` is registered. A bench must not drive it.
- All outputs are registered; there is no combinational path from `Req` or `Mem_Ack` to any output.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A `$clog2(TIMEOUT_CYCLES)`-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches `TIMEOUT_CYCLES-1` without `Mem_Ack`, the grant is released exactly as for an ack: `ptr` = winner+1 and the FSM returns to IDLE.
  - `Timeout_Err` pulses high in the first cycle after release.
  - If `Mem_Ack` and expiry fall in the same cycle, the ack wins and there is no error pulse.
- Undefined: there is no counter, BUSY waits indefinitely, and `Timeout_Err` is tied to 0 (the port stays present).

## Structure
- Shared package `arb_pkg` holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_BUSY`),
  - the `NUM_REQ` and `SEL_WIDTH` constants,
  - the requester index constants (`REQ_FETCH`=0, `REQ_LSU`=1, `REQ_DBG`=2, `REQ_DMA`=3).
- One sub-module, `rr_priority_pick`: combinational; inputs `Req[3:0]` and `ptr[1:0]`; outputs `winner[1:0]` and `any_req`. It is instantiated once.
- The registers, FSM and watchdog live in the top module.

## Test plan
- Reset, then `Req`=0000 for 5 cycles → `Grant`=0000, `Selector`=0, `Mem_Valid`=0 throughout.
- Single requester: `Req`=0100 at cycle 2 → `Grant`=0100 and `Selector`=2 from cycle 3. `Mem_Ack` at cycle 6 → `Grant`=0000 at cycle 7, `Selector` stays 2.
- Fairness: `Req`=1111 held, ack 2 cycles after each grant → grant order 0,1,2,3,0 with `Selector` 0,1,2,3,0. Each grant is separated by one idle cycle.
- Skip: `ptr`=1 (after serving index 0), `Req`=1001 → `Grant`=1000, `Selector`=3, then `ptr` wraps to 0.
- Reset mid-operation: assert `reset` asynchronously while `Grant`=0010 → `Grant`, `Mem_Valid` and `Selector` go to 0 before the next `clk` edge. After release with `Req`=0010, index 1 is granted again.
- `ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4: grant index 0 with no ack → `Grant` drops after 4 BUSY cycles, `Timeout_Err` pulses for 1 cycle, next grant goes to index 1 if requested.
